// File: rtl/alu_console_if.sv
// Operator-console bundle: switch bus and raw buttons in, registered ALU result and flags out.
interface alu_console_if #(
  parameter int unsigned N_BITS = 8
);
  logic [N_BITS-1:0] i_data_bus;
  logic              i_bt_a;
  logic              i_bt_b;
  logic              i_bt_op;
  logic [N_BITS-1:0] o_result;
  logic              o_zero;
  logic              o_carry;
  logic              o_overflow;
  logic              o_valid;
  logic [2:0]        o_loaded;

  modport master (
    output i_data_bus, i_bt_a, i_bt_b, i_bt_op,
    input  o_result, o_zero, o_carry, o_overflow, o_valid, o_loaded
  );

  modport slave (
    input  i_data_bus, i_bt_a, i_bt_b, i_bt_op,
    output o_result, o_zero, o_carry, o_overflow, o_valid, o_loaded
  );
endinterface

// File: rtl/alu_console.sv
// Bring-up console: debounced buttons load A, B and opcode from the switches into a registered ALU.
module alu_console #(
  parameter int unsigned N_BITS    = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned OP_BITS   = 6
) (
  input logic         i_clock,
  input logic         i_reset_n,
  alu_console_if.slave bus
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam int unsigned ShW  = $clog2(N_BITS);
  localparam int unsigned Msb  = N_BITS - 1;

  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t DbMax = cnt_t'(DB_CYCLES);
  localparam logic [N_BITS-1:0] WidthVal = N_BITS'(N_BITS);

  localparam logic [OP_BITS-1:0] OpAdd = OP_BITS'(6'b100000);
  localparam logic [OP_BITS-1:0] OpSub = OP_BITS'(6'b100010);
  localparam logic [OP_BITS-1:0] OpAnd = OP_BITS'(6'b100100);
  localparam logic [OP_BITS-1:0] OpOr  = OP_BITS'(6'b100101);
  localparam logic [OP_BITS-1:0] OpXor = OP_BITS'(6'b100110);
  localparam logic [OP_BITS-1:0] OpNor = OP_BITS'(6'b100111);
  localparam logic [OP_BITS-1:0] OpSra = OP_BITS'(6'b000011);
  localparam logic [OP_BITS-1:0] OpSrl = OP_BITS'(6'b000010);

  // Button chains, index 0 = A, 1 = B, 2 = opcode
  logic [2:0] raw, sync1_q, sync2_q, db_q, db_d, db_prev_q, load;
  cnt_t       cnt_q [3];
  cnt_t       cnt_d [3];

  assign raw  = {bus.i_bt_op, bus.i_bt_b, bus.i_bt_a};
  assign load = db_q & ~db_prev_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      db_d[i]  = 1'b0;
      if (sync2_q[i]) begin
        cnt_d[i] = (cnt_q[i] == DbMax) ? cnt_q[i] : cnt_q[i] + cnt_t'(1);
        db_d[i]  = db_q[i] | (cnt_d[i] == DbMax);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic [N_BITS-1:0]  a_q, b_q;
  logic [OP_BITS-1:0] op_q;
  logic [2:0]         loaded_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      loaded_q <= '0;
    end else begin
      if (load[0]) a_q  <= bus.i_data_bus;
      if (load[1]) b_q  <= bus.i_data_bus;
      if (load[2]) op_q <= OP_BITS'(bus.i_data_bus);
      loaded_q <= loaded_q | load;
    end
  end

  logic [N_BITS:0]   sum, diff;
  logic [N_BITS-1:0] res;
  logic [ShW-1:0]    shamt;
  logic              carry, ovf, big_shift;

  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = {1'b0, a_q} - {1'b0, b_q};
  assign shamt     = b_q[ShW-1:0];
  assign big_shift = (b_q >= WidthVal);

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_q)
      OpAdd: begin
        res   = sum[N_BITS-1:0];
        carry = sum[N_BITS];
        ovf   = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
      end
      OpSub: begin
        res   = diff[N_BITS-1:0];
        carry = diff[N_BITS];
        ovf   = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
      end
      OpAnd: res = a_q & b_q;
      OpOr:  res = a_q | b_q;
      OpXor: res = a_q ^ b_q;
      OpNor: res = ~(a_q | b_q);
      OpSra: res = big_shift ? {N_BITS{a_q[Msb]}} : $unsigned($signed(a_q) >>> shamt);
      OpSrl: res = big_shift ? '0 : (a_q >> shamt);
      default: res = '0;
    endcase
  end

  logic [N_BITS-1:0] result_q;
  logic              zero_q, carry_q, ovf_q, all_q, valid_q;

  // all_q tracks the result stage, so o_valid trails the first complete result by one cycle
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      all_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= res;
      zero_q   <= (res == '0);
      carry_q  <= carry;
      ovf_q    <= ovf;
      all_q    <= &loaded_q;
      valid_q  <= all_q;
    end
  end

  assign bus.o_result   = result_q;
  assign bus.o_zero     = zero_q;
  assign bus.o_carry    = carry_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_loaded   = loaded_q;

endmodule

// File: tb/tb_alu_console.sv
// Scoreboard bench for alu_console: button presses drive a model, settled outputs are compared.
module tb_alu_console;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       ovf;
    logic       valid;
    logic [2:0] loaded;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int         ma, mb, mop;
  logic [2:0] mloaded;

  alu_console_if #(.N_BITS(8)) dif ();

  alu_console #(
    .N_BITS   (8),
    .DB_CYCLES(4),
    .OP_BITS  (6)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sext(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   r = 0;
    int   s;
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    case (mop)
      'h20: begin
        r = ma + mb;
        s = sext(ma) + sext(mb);
        e.carry = (r > 255);
        e.ovf   = (s > 127) || (s < -128);
      end
      'h22: begin
        r = ma - mb + 256;
        s = sext(ma) - sext(mb);
        e.carry = (ma < mb);
        e.ovf   = (s > 127) || (s < -128);
      end
      'h24: r = ma & mb;
      'h25: r = ma | mb;
      'h26: r = ma ^ mb;
      'h27: r = ~(ma | mb);
      'h03: begin
        r = sext(ma);
        for (int k = 0; k < mb && k < 8; k++) r = (r < 0) ? -((1 - r) / 2) : r / 2;
      end
      'h02: r = (mb >= 8) ? 0 : ma / (1 << mb);
      default: r = 0;
    endcase
    e.result = 8'(r);
    e.zero   = (e.result == 8'h00);
    e.loaded = mloaded;
    e.valid  = (mloaded == 3'b111);
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(dif.o_result), 32'(e.result));
      check({tag, "_zero"}, 32'(dif.o_zero), 32'(e.zero));
      check({tag, "_carry"}, 32'(dif.o_carry), 32'(e.carry));
      check({tag, "_ovf"}, 32'(dif.o_overflow), 32'(e.ovf));
      check({tag, "_valid"}, 32'(dif.o_valid), 32'(e.valid));
      check({tag, "_loaded"}, 32'(dif.o_loaded), 32'(e.loaded));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, 32'(dif.o_result), 32'h0);
    check({tag, "_zero"}, 32'(dif.o_zero), 32'h0);
    check({tag, "_carry"}, 32'(dif.o_carry), 32'h0);
    check({tag, "_ovf"}, 32'(dif.o_overflow), 32'h0);
    check({tag, "_valid"}, 32'(dif.o_valid), 32'h0);
    check({tag, "_loaded"}, 32'(dif.o_loaded), 32'h0);
  endtask

  task automatic model_reset();
    ma = 0;
    mb = 0;
    mop = 0;
    mloaded = 3'b000;
  endtask

  task automatic set_buttons(input logic [2:0] m);
    dif.i_bt_a  = m[0];
    dif.i_bt_b  = m[1];
    dif.i_bt_op = m[2];
  endtask

  // Bus is scrambled while the button is still held, so any second load would corrupt the register
  task automatic press(input logic [2:0] mask, input logic [7:0] val, input string tag);
    dif.i_data_bus = val;
    set_buttons(mask);
    if (mask[0]) ma = int'(val);
    if (mask[1]) mb = int'(val);
    if (mask[2]) mop = int'(val[5:0]);
    mloaded |= mask;
    sb.push_back(model_out());
    repeat (8) step();
    dif.i_data_bus = ~val;
    repeat (4) step();
    set_buttons(3'b000);
    repeat (12) step();
    compare_out(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dif.i_data_bus = 8'h00;
    set_buttons(3'b000);
    model_reset();
    repeat (2) step();
    check_all_zero("in_reset");
    rst_n = 1'b1;
    repeat (3) step();
    sb.push_back(model_out());
    compare_out("after_reset");

    // Two-cycle glitch must not load
    dif.i_data_bus = 8'hAA;
    dif.i_bt_a = 1'b1;
    repeat (2) step();
    dif.i_bt_a = 1'b0;
    repeat (12) step();
    sb.push_back(model_out());
    compare_out("glitch");

    // Long press: load lands on the 7th edge (pulse after 6)
    dif.i_data_bus = 8'h05;
    dif.i_bt_a = 1'b1;
    repeat (6) step();
    check("a_before_pulse", 32'(dif.o_loaded), 32'h0);
    step();
    check("a_load_edge", 32'(dif.o_loaded), 32'h1);
    ma = 5;
    mloaded = 3'b001;
    step();
    dif.i_data_bus = 8'hFA;
    repeat (31) step();
    dif.i_bt_a = 1'b0;
    repeat (12) step();
    sb.push_back(model_out());
    compare_out("long_press");

    press(3'b010, 8'h03, "b_03");
    press(3'b100, 8'h20, "add_5_3");
    press(3'b001, 8'h7F, "a_7f");
    press(3'b010, 8'h01, "add_ovf");
    press(3'b100, 8'h22, "sub_7f_1");
    press(3'b001, 8'h00, "sub_borrow");
    press(3'b001, 8'h80, "a_80");
    press(3'b010, 8'h09, "b_09");
    press(3'b100, 8'h03, "sra_big");
    press(3'b100, 8'h02, "srl_big");
    press(3'b010, 8'h02, "srl_2");
    press(3'b100, 8'h03, "sra_2");
    press(3'b100, 8'h27, "nor");
    press(3'b100, 8'h25, "or");
    press(3'b100, 8'h26, "xor");
    press(3'b100, 8'h3F, "bad_op");

    // Simultaneous press from a fresh reset
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    dif.i_data_bus = 8'h24;
    set_buttons(3'b111);
    repeat (6) step();
    check("sim_before_pulse", 32'(dif.o_loaded), 32'h0);
    step();
    check("sim_loaded", 32'(dif.o_loaded), 32'h7);
    check("sim_result_pre", 32'(dif.o_result), 32'h0);
    step();
    check("sim_result", 32'(dif.o_result), 32'h24);
    check("sim_valid_pre", 32'(dif.o_valid), 32'h0);
    step();
    check("sim_valid", 32'(dif.o_valid), 32'h1);
    ma = 'h24;
    mb = 'h24;
    mop = 'h24;
    mloaded = 3'b111;
    dif.i_data_bus = 8'h5B;
    repeat (4) step();
    set_buttons(3'b000);
    repeat (12) step();
    sb.push_back(model_out());
    compare_out("sim_and");

    // Reset while B is held after it has loaded
    dif.i_data_bus = 8'h2C;
    dif.i_bt_b = 1'b1;
    repeat (8) step();
    check("pre_reset_result", 32'(dif.o_result), 32'h24);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    dif.i_data_bus = 8'h03;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    check("b_reload_early", 32'(dif.o_loaded), 32'h0);
    step();
    check("b_reload", 32'(dif.o_loaded), 32'h2);
    mb = 3;
    mloaded = 3'b010;
    dif.i_data_bus = 8'hF0;
    repeat (10) step();
    dif.i_bt_b = 1'b0;
    repeat (12) step();
    sb.push_back(model_out());
    compare_out("b_after_reset");
    press(3'b001, 8'h01, "a_01");
    press(3'b100, 8'h20, "add_1_3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
